// File: rtl/m_imem_loader_pkg.sv
// Shared definitions for the instruction memory loader:
// loader FSM encodings and the default imem geometry.
package m_imem_loader_pkg;

    localparam int DEPTH_DEF = 64;
    localparam int AW_DEF    = 6;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_DATA  = 3'd1,
        S_CHECK = 3'd2,
        S_DONE  = 3'd3,
        S_ERR   = 3'd4
    } state_t;

endpackage

// File: rtl/m_imem_loader_word_packer.sv
// Byte-to-word assembler for the loader: lane counter,
// little-endian assemble register and running payload XOR.
module m_word_packer (
    input  logic        w_clock,
    input  logic        w_reset_n,
    input  logic        w_clear,
    input  logic        w_accept,
    input  logic [7:0]  w_byte,
    output logic [31:0] w_word,
    output logic [7:0]  w_xor,
    output logic        w_word_done
);

    logic [1:0]  lane_q;
    logic [23:0] asm_q;
    logic [7:0]  xor_q;

    always_ff @(posedge w_clock) begin
        if (!w_reset_n) begin
            lane_q <= '0;
            asm_q  <= '0;
            xor_q  <= '0;
        end else if (w_clear) begin
            lane_q <= '0;
            asm_q  <= '0;
            xor_q  <= '0;
        end else if (w_accept) begin
            lane_q <= lane_q + 2'd1;
            asm_q  <= {w_byte, asm_q[23:8]};
            xor_q  <= xor_q ^ w_byte;
        end
    end

    // Lane-3 byte completes the word combinationally
    assign w_word      = {w_byte, asm_q};
    assign w_xor       = xor_q;
    assign w_word_done = w_accept && (lane_q == 2'd3);

endmodule

// File: rtl/m_imem_loader.sv
// Framed byte-stream program loader: writes imem words,
// checks the XOR checksum and releases the core.
module m_imem_loader
    import m_imem_loader_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = AW_DEF
) (
    input  logic          w_clock,
    input  logic          w_reset_n,
    input  logic          w_valid,
    input  logic [7:0]    w_byte,
    output logic          w_ready,
    output logic          w_we,
    output logic [AW-1:0] w_wa,
    output logic [31:0]   w_wd,
    output logic          w_run,
    output logic          w_error,
    output logic [AW:0]   w_nwords
);

    localparam logic [AW:0] ONE = 1;

    state_t        state_q, state_d;
    logic [AW:0]   n_q, k_q, nwords_q, n_load;
    logic          accept, count_ok, last_word;
    logic          pk_clear, pk_accept, word_done;
    logic [31:0]   word;
    logic [7:0]    xor_q;
    logic          we_q;
    logic [AW-1:0] wa_q;
    logic [31:0]   wd_q;

    m_word_packer u_packer (
        .w_clock     (w_clock),
        .w_reset_n   (w_reset_n),
        .w_clear     (pk_clear),
        .w_accept    (pk_accept),
        .w_byte      (w_byte),
        .w_word      (word),
        .w_xor       (xor_q),
        .w_word_done (word_done)
    );

    assign w_ready   = (state_q != S_DONE);
    assign accept    = w_valid && w_ready;
    assign count_ok  = (int'(w_byte) <= DEPTH);
    // A count of zero stands for a full memory image
    assign n_load    = (w_byte == 8'd0) ? (AW+1)'(DEPTH)
                                        : (AW+1)'(w_byte);
    assign last_word = ((k_q + ONE) == n_q);

    always_comb begin
        state_d   = state_q;
        pk_clear  = 1'b0;
        pk_accept = 1'b0;
        unique case (state_q)
            S_IDLE, S_ERR: begin
                if (accept) begin
                    state_d  = count_ok ? S_DATA : S_ERR;
                    pk_clear = count_ok;
                end
            end
            S_DATA: begin
                pk_accept = accept;
                if (word_done && last_word)
                    state_d = S_CHECK;
            end
            S_CHECK: begin
                if (accept)
                    state_d = (w_byte == xor_q) ? S_DONE : S_ERR;
            end
            S_DONE:  state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge w_clock) begin
        if (!w_reset_n) begin
            state_q  <= S_IDLE;
            n_q      <= '0;
            k_q      <= '0;
            nwords_q <= '0;
            we_q     <= 1'b0;
            wa_q     <= '0;
            wd_q     <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= word_done;
            if (pk_clear) begin
                n_q      <= n_load;
                k_q      <= '0;
                nwords_q <= '0;
            end else if (we_q) begin
                nwords_q <= nwords_q + ONE;
            end
            if (word_done) begin
                k_q  <= k_q + ONE;
                wa_q <= k_q[AW-1:0];
                wd_q <= word;
            end
        end
    end

    assign w_we     = we_q;
    assign w_wa     = wa_q;
    assign w_wd     = wd_q;
    assign w_nwords = nwords_q;
    assign w_run    = (state_q == S_DONE);
    assign w_error  = (state_q == S_ERR);

endmodule

// File: tb/tb_m_imem_loader.sv
// Self-checking bench for m_imem_loader: frame table,
// hand-written corner sequences and random throttled streams.
module tb_m_imem_loader;
    import m_imem_loader_pkg::*;

    localparam int DEPTH = DEPTH_DEF;
    localparam int AW    = AW_DEF;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          valid = 1'b0;
    logic [7:0]    bdata = 8'd0;
    logic          ready, we, run, error;
    logic [AW-1:0] wa;
    logic [31:0]   wd;
    logic [AW:0]   nwords;

    int checks = 0;
    int failures = 0;

    m_imem_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
        .w_clock   (clk),
        .w_reset_n (rst_n),
        .w_valid   (valid),
        .w_byte    (bdata),
        .w_ready   (ready),
        .w_we      (we),
        .w_wa      (wa),
        .w_wd      (wd),
        .w_run     (run),
        .w_error   (error),
        .w_nwords  (nwords)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Write monitor: every pulse must follow an accepted byte
    logic [AW-1:0] obs_a[$];
    logic [31:0]   obs_d[$];
    logic          acc_last = 1'b0;

    always @(posedge clk) acc_last <= valid & ready;

    always @(negedge clk) begin
        if (we) begin
            obs_a.push_back(wa);
            obs_d.push_back(wd);
            checks++;
            if (!acc_last) begin
                failures++;
                $display("FAIL we_without_accept actual=1 required=0");
            end
        end
    end

    // Reference model over a whole byte stream
    logic [7:0]    stm[$];
    logic [AW-1:0] exp_a[$];
    logic [31:0]   exp_d[$];
    bit            exp_run, exp_err;
    int            exp_nw;

    function automatic void model();
        int i, n;
        logic [7:0] x;
        i = 0;
        exp_a.delete();
        exp_d.delete();
        exp_run = 0;
        exp_err = 0;
        exp_nw = 0;
        while (i < stm.size() && !exp_run) begin
            n = int'(stm[i]);
            i++;
            if (n > DEPTH) begin
                exp_err = 1;
                continue;
            end
            exp_err = 0;
            exp_nw = 0;
            if (n == 0) n = DEPTH;
            x = 8'd0;
            for (int k = 0; k < n && i + 4 <= stm.size(); k++) begin
                exp_a.push_back(AW'(k));
                exp_d.push_back({stm[i+3], stm[i+2], stm[i+1], stm[i]});
                x = x ^ stm[i] ^ stm[i+1] ^ stm[i+2] ^ stm[i+3];
                i += 4;
                exp_nw++;
            end
            if (i < stm.size()) begin
                exp_run = (stm[i] == x);
                exp_err = !exp_run;
                i++;
            end
        end
    endfunction

    function automatic void add_frame(input logic [7:0] cnt, input bit bad,
                                      input bit rnd);
        int n;
        logic [7:0] x;
        logic [31:0] w;
        stm.push_back(cnt);
        if (int'(cnt) > DEPTH) return;
        n = (cnt == 8'd0) ? DEPTH : int'(cnt);
        x = 8'd0;
        for (int k = 0; k < n; k++) begin
            w = rnd ? $urandom : k;
            for (int b = 0; b < 4; b++) begin
                stm.push_back(w[8*b +: 8]);
                x = x ^ w[8*b +: 8];
            end
        end
        stm.push_back(bad ? (x ^ 8'h01) : x);
    endfunction

    function automatic void good_frame(input logic [7:0] cs);
        logic [7:0] f[$];
        f = '{8'h02, 8'h13, 8'h00, 8'h00, 8'h00,
              8'h93, 8'h00, 8'h10, 8'h00};
        foreach (f[i]) stm.push_back(f[i]);
        stm.push_back(cs);
    endfunction

    task automatic send(input logic [7:0] b, input int gap);
        valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        valid = 1'b1;
        bdata = b;
        @(posedge clk);
        #1;
        valid = 1'b0;
    endtask

    task automatic play(input int maxgap);
        foreach (stm[i]) send(stm[i], $urandom_range(0, maxgap));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        valid = 1'b0;
        bdata = 8'd0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b1;
        obs_a.delete();
        obs_d.delete();
    endtask

    task automatic compare_all(input string tag);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check({tag, "_nwrites"}, obs_a.size(), exp_a.size());
        for (int i = 0; i < exp_a.size() && i < obs_a.size(); i++) begin
            check($sformatf("%s_wa%0d", tag, i), obs_a[i], exp_a[i]);
            check($sformatf("%s_wd%0d", tag, i), obs_d[i], exp_d[i]);
        end
        check({tag, "_run"}, run, exp_run);
        check({tag, "_error"}, error, exp_err);
        check({tag, "_ready"}, ready, !exp_run);
        check({tag, "_nwords"}, nwords, exp_nw);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_run"}, run, 0);
        check({tag, "_error"}, error, 0);
        check({tag, "_we"}, we, 0);
        check({tag, "_wa"}, wa, 0);
        check({tag, "_wd"}, wd, 0);
        check({tag, "_nwords"}, nwords, 0);
        check({tag, "_ready"}, ready, 1);
    endtask

    typedef struct {
        string      name;
        logic [7:0] cnt;
        bit         bad;
        bit         e_run;
        bit         e_err;
        int         e_wr;
    } vec_t;

    vec_t tbl[7];
    int   sel;
    logic [7:0] c;
    bit   bad;

    initial begin
        tbl[0] = '{"two",     8'h02, 1'b0, 1'b1, 1'b0, 2};
        tbl[1] = '{"badcs",   8'h02, 1'b1, 1'b0, 1'b1, 2};
        tbl[2] = '{"ill41",   8'h41, 1'b0, 1'b0, 1'b1, 0};
        tbl[3] = '{"illff",   8'hff, 1'b0, 1'b0, 1'b1, 0};
        tbl[4] = '{"one",     8'h01, 1'b0, 1'b1, 1'b0, 1};
        tbl[5] = '{"full0",   8'h00, 1'b0, 1'b1, 1'b0, 64};
        tbl[6] = '{"n64",     8'h40, 1'b0, 1'b1, 1'b0, 64};

        // Reset state and exact release timing of the reference frame
        do_reset();
        check_reset_vals("rst");
        stm.delete();
        good_frame(8'h90);
        for (int i = 0; i < 9; i++) send(stm[i], 0);
        check("pre_cs_run", run, 0);
        send(8'h90, 0);
        check("cs_edge_run", run, 1);
        check("cs_edge_ready", ready, 0);
        check("cs_edge_error", error, 0);
        check("good_nwr", obs_d.size(), 2);
        if (obs_d.size() == 2) begin
            check("good_wd0", obs_d[0], 32'h0000_0013);
            check("good_wd1", obs_d[1], 32'h0010_0093);
        end

        // Frame table, each from reset
        for (int t = 0; t < 7; t++) begin
            do_reset();
            stm.delete();
            add_frame(tbl[t].cnt, tbl[t].bad, tbl[t].cnt != 8'h00);
            model();
            play(0);
            compare_all(tbl[t].name);
            check({tbl[t].name, "_trun"}, run, tbl[t].e_run);
            check({tbl[t].name, "_terr"}, error, tbl[t].e_err);
            check({tbl[t].name, "_twr"}, obs_a.size(), tbl[t].e_wr);
        end

        // Bad checksum, then recovery on the next count byte
        do_reset();
        stm.delete();
        good_frame(8'h91);
        play(0);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        check("bad_error", error, 1);
        check("bad_run", run, 0);
        check("bad_nwr", obs_a.size(), 2);
        send(8'h02, 0);
        check("recover_err_clr", error, 0);
        stm.delete();
        good_frame(8'h90);
        for (int i = 1; i < 10; i++) send(stm[i], 0);
        check("recover_run", run, 1);

        // Illegal count goes to ERR on its edge, then a legal frame loads
        do_reset();
        send(8'h41, 0);
        check("ill_error", error, 1);
        check("ill_ready", ready, 1);
        stm.delete();
        good_frame(8'h90);
        model();
        play(0);
        compare_all("ill_then_good");

        // Reset on the edge accepting lane 3 of word 0
        do_reset();
        send(8'h02, 0);
        send(8'h13, 0);
        send(8'h00, 0);
        send(8'h00, 0);
        valid = 1'b1;
        bdata = 8'h00;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        valid = 1'b0;
        rst_n = 1'b1;
        check_reset_vals("midrst");
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        check("midrst_nwr", obs_a.size(), 0);
        stm.delete();
        good_frame(8'h90);
        model();
        play(0);
        compare_all("midrst_reload");

        // Throttled reference frame
        do_reset();
        stm.delete();
        good_frame(8'h90);
        model();
        play(5);
        compare_all("throttled");

        // Random frame sequences with random gaps
        for (int r = 0; r < 16; r++) begin
            do_reset();
            stm.delete();
            for (int f = 0; f < 3; f++) begin
                sel = $urandom_range(0, 5);
                c = (sel == 0) ? 8'($urandom_range(65, 255))
                               : 8'($urandom_range(1, 6));
                bad = (sel == 1);
                add_frame(c, bad, 1'b1);
                if (int'(c) <= DEPTH && !bad) break;
            end
            model();
            play(5);
            compare_all($sformatf("rnd%0d", r));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
